sequence_player: RTL and testbench

Plays the stored Simon colour sequence back to the four LEDs: each entry is lit for a fixed on-time, followed by a dark gap. The game controller appends one colour per won round and pulses `start` at the beginning of each round. The block sits between the game FSM and the LED drivers. It is the output side of the sequence path; the input side compares the player's presses against the same sequence.

---
 rtl/sequence_player.sv | 152 +++++++++++++++
 tb/tb_sequence_player.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_player.sv
// Plays the stored Simon colour sequence to the LEDs. Each entry is lit for ON_CYCLES
// cycles and then followed by OFF_CYCLES dark cycles. Colours are appended one per won round.
module sequence_player #(
   parameter int unsigned ON_CYCLES  = 25_000_000,
   parameter int unsigned OFF_CYCLES = 12_500_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       add_valid,
   input  logic [1:0] add_color,
   input  logic       start,
   output logic [3:0] led,
   output logic       busy,
   output logic       done,
   output logic [5:0] length,
   output logic       full
);

   localparam logic [31:0] ON_LAST  = 32'(ON_CYCLES - 1);
   localparam logic [31:0] OFF_LAST = 32'(OFF_CYCLES - 1);
   localparam logic [5:0]  DEPTH    = 6'd32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  pos_q, pos_d;
   logic [31:0] timer_q, timer_d;
   logic [5:0]  length_q, length_d;
   logic [3:0]  led_q, led_d;
   logic        done_q, done_d;

   logic [1:0]  mem [32];
   logic        mem_we;
   logic [4:0]  pos_next;
   logic        full_w;
   logic        last_entry;

   function automatic logic [3:0] onehot(input logic [1:0] color);
      onehot = 4'b0001 << color;
   endfunction

   assign full_w     = (length_q == DEPTH);
   assign pos_next   = pos_q + 5'd1;
   // length is never 0 outside IDLE, so length-1 cannot underflow here
   assign last_entry = ({1'b0, pos_q} == (length_q - 6'd1));

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      timer_d  = timer_q;
      length_d = length_q;
      led_d    = led_q;
      done_d   = 1'b0;
      mem_we   = 1'b0;

      if (add_valid && (state_q == S_IDLE) && !full_w) begin
         mem_we   = 1'b1;
         length_d = length_q + 6'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (length_q != 6'd0) begin
                  state_d = S_ON;
                  pos_d   = 5'd0;
                  timer_d = 32'd0;
                  led_d   = onehot(mem[0]);
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_ON: begin
            if (timer_q == ON_LAST) begin
               state_d = S_OFF;
               timer_d = 32'd0;
               led_d   = 4'b0000;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_OFF: begin
            if (timer_q == OFF_LAST) begin
               timer_d = 32'd0;
               if (last_entry) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ON;
                  pos_d   = pos_next;
                  led_d   = onehot(mem[pos_next]);
               end
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            led_d   = 4'b0000;
         end
      endcase

      // clear wins over append, start and any playback step
      if (clear) begin
         state_d  = S_IDLE;
         pos_d    = 5'd0;
         timer_d  = 32'd0;
         length_d = 6'd0;
         led_d    = 4'b0000;
         done_d   = 1'b0;
         mem_we   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         pos_q    <= 5'd0;
         timer_q  <= 32'd0;
         length_q <= 6'd0;
         led_q    <= 4'b0000;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         timer_q  <= timer_d;
         length_q <= length_d;
         led_q    <= led_d;
         done_q   <= done_d;
      end
   end

   // Sequence storage carries no reset; only indices below length are read.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[length_q[4:0]] <= add_color;
      end
   end

   assign led    = led_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign length = length_q;
   assign full   = full_w;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON_CYCLES=3, OFF_CYCLES=2.
module tb_sequence_player;

   logic       clk;
   logic       reset_n;
   logic       clear;
   logic       add_valid;
   logic [1:0] add_color;
   logic       start;
   logic [3:0] led;
   logic       busy;
   logic       done;
   logic [5:0] length;
   logic       full;

   int checks;
   int errors;

   logic [3:0] exp_led_203 [15] = '{
      4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
      4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
      4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000
   };

   sequence_player #(.ON_CYCLES(3), .OFF_CYCLES(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .add_valid (add_valid),
      .add_color (add_color),
      .start     (start),
      .led       (led),
      .busy      (busy),
      .done      (done),
      .length    (length),
      .full      (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic append(input logic [1:0] c);
      add_valid = 1'b1;
      add_color = c;
      step();
      add_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      checks++;
      if ({led, busy, done, length, full} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got led=%b busy=%b done=%b length=%0d full=%b, want all 0",
                  led, busy, done, length, full);
      end
      #10;
      reset_n = 1'b1;
      step();
      checks++;
      if ({led, busy, done, length, full} !== 13'd0) begin
         errors++;
         $display("FAIL after_reset_release: got led=%b busy=%b done=%b length=%0d, want all 0",
                  led, busy, done, length);
      end
   endtask

   task automatic test_playback();
      append(2'd2);
      append(2'd0);
      append(2'd3);
      checks++;
      if (length !== 6'd3) begin
         errors++;
         $display("FAIL play_length: got %0d want 3", length);
      end
      pulse_start();
      for (int i = 0; i < 15; i++) begin
         checks++;
         if (led !== exp_led_203[i] || busy !== 1'b1 || done !== 1'b0 || length !== 6'd3) begin
            errors++;
            $display("FAIL play_cycle%0d: got led=%b busy=%b done=%b len=%0d want led=%b busy=1 done=0 len=3",
                     i + 1, led, busy, done, length, exp_led_203[i]);
         end
         step();
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b1 || led !== 4'b0000) begin
         errors++;
         $display("FAIL play_done: got busy=%b done=%b led=%b want busy=0 done=1 led=0000",
                  busy, done, led);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL play_done_width: got done=%b want 0", done);
      end
   endtask

   task automatic test_fill();
      logic [3:0] exp;
      do_clear();
      for (int i = 0; i < 32; i++) append(2'(i % 4));
      checks++;
      if (length !== 6'd32 || full !== 1'b1) begin
         errors++;
         $display("FAIL fill_32: got length=%0d full=%b want 32 / 1", length, full);
      end
      append(2'd1);
      checks++;
      if (length !== 6'd32 || full !== 1'b1) begin
         errors++;
         $display("FAIL fill_33rd_ignored: got length=%0d full=%b want 32 / 1", length, full);
      end
      pulse_start();
      for (int k = 0; k < 32; k++) begin
         for (int j = 0; j < 5; j++) begin
            exp = (j < 3) ? (4'b0001 << (k % 4)) : 4'b0000;
            checks++;
            if (led !== exp || busy !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL fill_play_e%0d_c%0d: got led=%b busy=%b done=%b want led=%b busy=1 done=0",
                        k, j, led, busy, done, exp);
            end
            step();
         end
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL fill_play_done: got busy=%b done=%b want 0 / 1", busy, done);
      end
   endtask

   task automatic test_empty_start();
      do_clear();
      checks++;
      if (length !== 6'd0 || full !== 1'b0) begin
         errors++;
         $display("FAIL empty_cleared: got length=%0d full=%b want 0 / 0", length, full);
      end
      pulse_start();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || led !== 4'b0000) begin
         errors++;
         $display("FAIL empty_done: got done=%b busy=%b led=%b want 1 / 0 / 0000", done, busy, led);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || led !== 4'b0000) begin
            errors++;
            $display("FAIL empty_after%0d: got done=%b busy=%b led=%b want 0 / 0 / 0000",
                     i, done, busy, led);
         end
      end
   endtask

   task automatic test_ignored_inputs();
      int busy_cycles;
      do_clear();
      append(2'd2);
      append(2'd0);
      append(2'd3);
      pulse_start();
      busy_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy === 1'b1) busy_cycles++;
         checks++;
         if (length !== 6'd3) begin
            errors++;
            $display("FAIL ignore_length_c%0d: got %0d want 3", i + 1, length);
         end
         if (i < 15) begin
            checks++;
            if (led !== exp_led_203[i]) begin
               errors++;
               $display("FAIL ignore_led_c%0d: got %b want %b", i + 1, led, exp_led_203[i]);
            end
         end
         start     = (i == 3);
         add_valid = (i == 5);
         add_color = 2'd1;
         step();
         start     = 1'b0;
         add_valid = 1'b0;
      end
      checks++;
      if (busy_cycles !== 15) begin
         errors++;
         $display("FAIL ignore_busy_time: got %0d cycles want 15", busy_cycles);
      end
   endtask

   task automatic test_clear_mid();
      int done_seen;
      do_clear();
      append(2'd2);
      append(2'd0);
      append(2'd3);
      pulse_start();
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (done === 1'b1) done_seen++;
         step();
      end
      // now in cycle 7: second entry lit
      checks++;
      if (led !== 4'b0001 || busy !== 1'b1) begin
         errors++;
         $display("FAIL clear_pre: got led=%b busy=%b want 0001 / 1", led, busy);
      end
      do_clear();
      checks++;
      if (busy !== 1'b0 || led !== 4'b0000 || length !== 6'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL clear_post: got busy=%b led=%b length=%0d done=%b want 0 / 0000 / 0 / 0",
                  busy, led, length, done);
      end
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1 || busy === 1'b1) done_seen++;
         step();
      end
      checks++;
      if (done_seen !== 0) begin
         errors++;
         $display("FAIL clear_no_done: got %0d done/busy cycles want 0", done_seen);
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      append(2'd1);
      append(2'd2);
      pulse_start();
      step();
      checks++;
      if (led !== 4'b0010 || busy !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: got led=%b busy=%b want 0010 / 1", led, busy);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (led !== 4'b0000 || busy !== 1'b0 || length !== 6'd0 || done !== 1'b0 || full !== 1'b0) begin
         errors++;
         $display("FAIL areset_immediate: got led=%b busy=%b length=%0d done=%b want all 0",
                  led, busy, length, done);
      end
      #12;
      reset_n = 1'b1;
      step();
      pulse_start();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || led !== 4'b0000) begin
         errors++;
         $display("FAIL areset_start_done: got done=%b busy=%b led=%b want 1 / 0 / 0000",
                  done, busy, led);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL areset_start_after: got done=%b busy=%b want 0 / 0", done, busy);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset_n   = 1'b0;
      clear     = 1'b0;
      add_valid = 1'b0;
      add_color = 2'd0;
      start     = 1'b0;
      test_reset();
      test_playback();
      test_fill();
      test_empty_start();
      test_ignored_inputs();
      test_clear_mid();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
